// File: rtl/bus_handshakes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_handshakes_pkg
// Description : Shared types and constants for the bus_handshakes register
//               slice: occupancy state encoding and default payload width.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_handshakes_pkg;

    // Default payload width of the slice
    localparam int c_DEFAULT_WIDTH = 32;

    // Occupancy of the slice: nothing held, main register held, main + skid held
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } hs_state_t;

endpackage : bus_handshakes_pkg
`default_nettype wire

// File: rtl/bus_handshakes.sv
`default_nettype none
// ============================================================================
// Module      : bus_handshakes
// Description : Valid/ready pipeline register slice (full skid buffer).
//               Forward path (valid_o, data_o) and backward path (ready_o)
//               are both driven straight from flops, so no combinational
//               path crosses the block in either direction. Sustains one
//               beat per clock, preserves order, never drops a beat.
// Ports       : clk      - clock, all logic on rising edge
//               rstn     - synchronous reset, ACTIVE-HIGH despite its name
//               valid_i  - upstream beat valid
//               ready_o  - upstream may transfer (registered)
//               data_i   - upstream payload, sampled on accept
//               valid_o  - downstream beat valid (registered)
//               ready_i  - downstream accepts
//               data_o   - downstream payload (registered, main register)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_handshakes
    import bus_handshakes_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    hs_state_t        r_state;
    logic             r_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_in;
    logic             w_out;

    // Handshakes use only registered outputs on our side, so neither
    // ready_o nor valid_o/data_o can see the opposite side combinationally.
    assign w_in  = valid_i && r_ready;
    assign w_out = r_valid && ready_i;

    always_ff @(posedge clk) begin
        if (rstn) begin
            // ready_o is held low during reset and rises on the first
            // edge after release (EMPTY branch below).
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_ready <= 1'b1;
                    if (w_in) begin
                        r_main  <= data_i;
                        r_valid <= 1'b1;
                        r_state <= ONE;
                    end
                end

                ONE: begin
                    if (w_in && w_out) begin
                        r_main <= data_i;
                    end else if (w_in) begin
                        // Downstream stalled: park the new beat in the skid
                        // register and stop accepting.
                        r_skid  <= data_i;
                        r_ready <= 1'b0;
                        r_state <= FULL;
                    end else if (w_out) begin
                        // data_o keeps its last value while empty
                        r_valid <= 1'b0;
                        r_state <= EMPTY;
                    end
                end

                FULL: begin
                    // ready_o is low here, so no accept can coincide
                    if (w_out) begin
                        r_main  <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= ONE;
                    end
                end

                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_main;

endmodule : bus_handshakes
`default_nettype wire

// File: tb/tb_bus_handshakes.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_handshakes
// Description : Self-checking bench for bus_handshakes. A queue of accepted
//               beats predicts the payload; occupancy of that queue predicts
//               valid_o and ready_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_handshakes;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rstn;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;

    bus_handshakes #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard / model state
    logic [WIDTH-1:0] q[$];
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_dout;
    bit               m_known;
    int               n_pass;
    int               n_total;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock of stimulus: drive, check current outputs, advance model.
    task automatic cycle(input logic v, input logic r, input logic [WIDTH-1:0] d,
                         input logic rs, output bit accepted);
        bit acc;
        bit dep;
        valid_i = v;
        ready_i = r;
        data_i  = d;
        rstn    = rs;
        if (m_known) begin
            chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
            chk("ready_o", {31'd0, ready_o}, {31'd0, m_ready});
            chk("data_o",  data_o, m_dout);
        end
        acc = v && m_ready && !rs;
        dep = m_valid && r && !rs;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_valid = 1'b0;
            m_ready = 1'b0;
            m_dout  = '0;
        end else begin
            if (dep) void'(q.pop_front());
            if (acc) q.push_back(d);
            m_valid = (q.size() > 0);
            m_ready = (q.size() < 2);
            if (q.size() > 0) m_dout = q[0];
        end
        m_known  = 1'b1;
        accepted = acc;
    endtask

    task automatic idle(input logic r, input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, r, '0, 1'b0, a);
    endtask

    // Send n consecutive values from base; mode 0: ready_i=1,
    // 1: ready_i=0 for the first dly cycles, 2: ready_i toggles.
    task automatic stream(input logic [WIDTH-1:0] base, input int n, input int mode, input int dly);
        int  k;
        int  cyc;
        bit  a;
        logic r;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc >= dly);
                default: r = cyc[0];
            endcase
            cycle(1'b1, r, base + k, 1'b0, a);
            if (a) k++;
            cyc++;
        end
        if (k < n) begin
            n_total++;
            $error("FAIL stream_timeout observed=%0d expected=%0d", k, n);
        end
    endtask

    initial begin
        bit a;
        n_pass  = 0;
        n_total = 0;
        m_known = 1'b0;
        m_valid = 1'b0;
        m_ready = 1'b0;
        m_dout  = '0;
        rstn    = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;

        // Reset, then streaming at full rate
        cycle(1'b0, 1'b0, '0, 1'b1, a);
        cycle(1'b0, 1'b0, '0, 1'b1, a);
        idle(1'b0, 2);
        stream(32'd3, 4, 0, 0);
        idle(1'b1, 2);

        // Valid before ready: fill to FULL, then drain in order
        stream(32'd10, 4, 1, 4);
        idle(1'b1, 4);

        // Ready before valid
        idle(1'b1, 2);
        stream(32'd20, 3, 0, 0);
        idle(1'b1, 2);

        // Short pulses: one valid pulse, later one ready pulse
        cycle(1'b1, 1'b0, 32'd7, 1'b0, a);
        idle(1'b0, 2);
        cycle(1'b0, 1'b1, '0, 1'b0, a);
        idle(1'b0, 2);

        // Reset while FULL: held beats must vanish
        cycle(1'b1, 1'b0, 32'd40, 1'b0, a);
        cycle(1'b1, 1'b0, 32'd41, 1'b0, a);
        cycle(1'b1, 1'b0, 32'd42, 1'b0, a);
        cycle(1'b0, 1'b1, '0, 1'b1, a);
        idle(1'b1, 3);

        // Alternating back-pressure
        stream(32'd30, 8, 2, 0);
        idle(1'b1, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bus_handshakes
`default_nettype wire
